// File: rtl/pdes_pkg.sv
// Shared definitions for the PDES event scheduling controller:
// message layout helpers, null-message detection and the controller state encoding.
package pdes_pkg;

    // Widest message the helper functions handle; callers zero-extend into this width.
    localparam int MSG_MAX = 64;

    // Default field widths used by the controller parameters.
    localparam int DEF_TIME_WID = 16;
    localparam int DEF_NB_LPID  = 5;
    localparam int DEF_MSG_WID  = 32;

    // Field layout for the default widths: time at the bottom, LP id above it, cancel bit on top.
    localparam int TIME_LSB   = 0;
    localparam int LP_LSB     = DEF_TIME_WID;
    localparam int CANCEL_BIT = DEF_TIME_WID + DEF_NB_LPID;

    // Null message (cancel=1, LP=0, time=0) for the default widths.
    localparam logic [DEF_MSG_WID-1:0] NULL_MSG = 32'h0020_0000;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Null message for arbitrary field widths: only the cancel bit set.
    function automatic logic [MSG_MAX-1:0] null_msg(input int time_wid, input int lpid_wid);
        null_msg = {{(MSG_MAX-1){1'b0}}, 1'b1} << (time_wid + lpid_wid);
    endfunction

    // True when msg is the null message; such offers are acknowledged but never queued.
    function automatic logic is_null(input logic [MSG_MAX-1:0] msg, input int time_wid,
                                     input int lpid_wid);
        is_null = (msg == null_msg(time_wid, lpid_wid));
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: combinational grant starting from a rotating pointer.
// The pointer moves one past the winner only when adv is asserted with a live grant.
module rr_arb #(
    parameter int NR = 4,
    localparam int IW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NR-1:0] req,
    input  logic          adv,
    output logic [NR-1:0] gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    localparam logic [IW:0] NR_W = (IW+1)'(NR);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   sum_s;
    logic [IW:0]   pos_s;
    logic          take_s;
    logic          found_s;

    // Scan requesters from the pointer upward (with wrap) and grant the first one.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found_s    = 1'b0;
        sum_s      = '0;
        pos_s      = '0;
        take_s     = 1'b0;
        for (int k = 0; k < NR; k++) begin
            sum_s  = {1'b0, ptr_q} + (IW+1)'(k);
            pos_s  = (sum_s >= NR_W) ? (sum_s - NR_W) : sum_s;
            take_s = !found_s && req[pos_s[IW-1:0]];
            gnt_onehot[pos_s[IW-1:0]] = gnt_onehot[pos_s[IW-1:0]] | take_s;
            gnt_idx = take_s ? pos_s[IW-1:0] : gnt_idx;
            found_s = found_s | take_s;
        end
        any = |req;
    end

    // Next pointer: one past the winner on an actual grant, otherwise unchanged.
    always_comb begin
        if (adv && any) begin
            ptr_d = (gnt_idx == IW'(NR-1)) ? '0 : gnt_idx + IW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pdes_sched_ctrl.sv
// Event scheduling controller for the PDES/PHOLD engine. Seeds the external
// priority queue with one event per LP, then each cycle either enqueues one
// core-generated event or dispatches the queue head to an idle core. Tracks
// GVT, throttles optimism with a time window and ends the run with a drain.
module pdes_sched_ctrl
    import pdes_pkg::*;
#(
    parameter int NUM_CORE = 16,
    parameter int NUM_LP   = 32,
    parameter int NB_LPID  = DEF_NB_LPID,
    parameter int TIME_WID = DEF_TIME_WID,
    parameter int MSG_WID  = DEF_MSG_WID,
    parameter int CNT_WID  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [TIME_WID-1:0]          sim_end_time,
    input  logic [TIME_WID-1:0]          window,
    input  logic [NUM_CORE-1:0]          core_ready,
    output logic [NUM_CORE-1:0]          core_evt_vld,
    output logic [MSG_WID-1:0]           core_evt_data,
    input  logic [NUM_CORE-1:0]          core_new_vld,
    input  logic [NUM_CORE*MSG_WID-1:0]  core_new_data,
    output logic [NUM_CORE-1:0]          core_new_ack,
    input  logic [NUM_CORE-1:0]          core_busy,
    input  logic [NUM_CORE*TIME_WID-1:0] core_time,
    output logic                         q_enq,
    output logic [MSG_WID-1:0]           q_enq_data,
    output logic                         q_deq,
    input  logic [MSG_WID-1:0]           q_head,
    input  logic                         q_empty,
    input  logic                         q_full,
    output logic [TIME_WID-1:0]          gvt,
    output logic                         done,
    output logic                         running,
    output logic                         err,
    output logic [CNT_WID-1:0]           n_dispatched
);

    localparam int CIW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam logic [NB_LPID-1:0] LAST_LP = NB_LPID'(NUM_LP - 1);

    state_e              state_q, state_d;
    logic [NB_LPID-1:0]  init_cnt_q, init_cnt_d;
    logic [TIME_WID-1:0] gvt_q, gvt_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                running_q, running_d;
    logic [CNT_WID-1:0]  n_disp_q, n_disp_d;

    logic                active_s;
    logic                run_over_s;
    logic [NUM_CORE-1:0] req_a_s, gnt_a_s, req_b_s, gnt_b_s;
    logic [CIW-1:0]      idx_a_s, idx_b_unused_s;
    logic                any_a_s, any_b_s;
    logic [MSG_WID-1:0]  enq_src_s;
    logic [TIME_WID-1:0] head_time_s;
    logic [TIME_WID:0]   win_lim_s;
    logic                win_ok_s;
    logic                disp_ok_s;
    logic [TIME_WID-1:0] cand_s;
    logic                cand_vld_s;
    logic                gvt_regress_s;

    assign active_s    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign run_over_s  = (gvt_q > sim_end_time);
    assign head_time_s = q_head[TIME_WID-1:0];

    // Window limit is formed one bit wider so gvt+window never wraps.
    assign win_lim_s = {1'b0, gvt_q} + {1'b0, window};
    assign win_ok_s  = (window == '0) || ({1'b0, head_time_s} < win_lim_s);

    // Enqueue has priority; dispatch only in RUN, before the end time, and within the window.
    assign req_a_s   = core_new_vld & {NUM_CORE{active_s & ~q_full}};
    assign disp_ok_s = (state_q == ST_RUN) && !run_over_s && !any_a_s && !q_empty && win_ok_s;
    assign req_b_s   = core_ready & {NUM_CORE{disp_ok_s}};

    rr_arb #(.NR(NUM_CORE)) u_arb_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_a_s),
        .adv        (any_a_s),
        .gnt_onehot (gnt_a_s),
        .gnt_idx    (idx_a_s),
        .any        (any_a_s)
    );

    rr_arb #(.NR(NUM_CORE)) u_arb_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_b_s),
        .adv        (any_b_s),
        .gnt_onehot (gnt_b_s),
        .gnt_idx    (idx_b_unused_s),
        .any        (any_b_s)
    );

    assign enq_src_s     = core_new_data[idx_a_s*MSG_WID +: MSG_WID];
    assign core_new_ack  = gnt_a_s;
    assign core_evt_vld  = gnt_b_s;
    assign core_evt_data = q_head;
    assign q_deq         = any_b_s;

    // Queue write port: seeding events during INIT, granted non-null offers otherwise.
    always_comb begin
        q_enq      = 1'b0;
        q_enq_data = '0;
        if (state_q == ST_INIT) begin
            q_enq                         = 1'b1;
            q_enq_data[TIME_WID +: NB_LPID] = init_cnt_q;
        end else begin
            q_enq      = any_a_s && !is_null(MSG_MAX'(enq_src_s), TIME_WID, NB_LPID);
            q_enq_data = enq_src_s;
        end
    end

    // GVT candidate: minimum timestamp over busy cores and the non-empty queue head.
    always_comb begin
        cand_s     = '1;
        cand_vld_s = 1'b0;
        for (int i = 0; i < NUM_CORE; i++) begin
            cand_s = (core_busy[i] && (!cand_vld_s || core_time[i*TIME_WID +: TIME_WID] < cand_s))
                     ? core_time[i*TIME_WID +: TIME_WID] : cand_s;
            cand_vld_s = cand_vld_s | core_busy[i];
        end
        cand_s        = (!q_empty && (!cand_vld_s || head_time_s < cand_s)) ? head_time_s : cand_s;
        cand_vld_s    = cand_vld_s | !q_empty;
        gvt_regress_s = cand_vld_s && (cand_s < gvt_q);
    end

    // Controller next-state, seeding counter, GVT, error and dispatch counter.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        gvt_d      = gvt_q;
        err_d      = err_q;
        n_disp_d   = n_disp_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                    gvt_d      = '0;
                    err_d      = 1'b0;
                    n_disp_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (q_full) begin
                    err_d = 1'b1;
                end else if (init_cnt_q == LAST_LP) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + NB_LPID'(1);
                end
            end
            ST_RUN: begin
                gvt_d    = (cand_vld_s && !gvt_regress_s) ? cand_s : gvt_q;
                err_d    = err_q | gvt_regress_s;
                n_disp_d = n_disp_q + {{(CNT_WID-1){1'b0}}, any_b_s};
                if (run_over_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                gvt_d = (cand_vld_s && !gvt_regress_s) ? cand_s : gvt_q;
                err_d = err_q | gvt_regress_s;
                if ((core_busy == '0) && (core_new_vld == '0)) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d    = (state_d == ST_FINISH);
        running_d = (state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
            gvt_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            running_q  <= 1'b0;
            n_disp_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            gvt_q      <= gvt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            running_q  <= running_d;
            n_disp_q   <= n_disp_d;
        end
    end

    assign gvt          = gvt_q;
    assign err          = err_q;
    assign done         = done_q;
    assign running      = running_q;
    assign n_dispatched = n_disp_q;

endmodule

// File: tb/tb_pdes_sched_ctrl.sv
// Directed bench for pdes_sched_ctrl: seeding, dispatch fairness, enqueue/dispatch
// conflict, null filtering, window throttling, drain/finish and async reset.
module tb_pdes_sched_ctrl;

    localparam int NC = 16;
    localparam int NL = 32;
    localparam int LW = 5;
    localparam int TW = 16;
    localparam int MW = 32;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [TW-1:0]     sim_end_time;
    logic [TW-1:0]     window;
    logic [NC-1:0]     core_ready;
    logic [NC-1:0]     core_evt_vld;
    logic [MW-1:0]     core_evt_data;
    logic [NC-1:0]     core_new_vld;
    logic [NC*MW-1:0]  core_new_data;
    logic [NC-1:0]     core_new_ack;
    logic [NC-1:0]     core_busy;
    logic [NC*TW-1:0]  core_time;
    logic              q_enq;
    logic [MW-1:0]     q_enq_data;
    logic              q_deq;
    logic [MW-1:0]     q_head;
    logic              q_empty;
    logic              q_full;
    logic [TW-1:0]     gvt;
    logic              done;
    logic              running;
    logic              err;
    logic [CW-1:0]     n_dispatched;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pdes_sched_ctrl #(
        .NUM_CORE (NC), .NUM_LP (NL), .NB_LPID (LW),
        .TIME_WID (TW), .MSG_WID (MW), .CNT_WID (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .sim_end_time  (sim_end_time),
        .window        (window),
        .core_ready    (core_ready),
        .core_evt_vld  (core_evt_vld),
        .core_evt_data (core_evt_data),
        .core_new_vld  (core_new_vld),
        .core_new_data (core_new_data),
        .core_new_ack  (core_new_ack),
        .core_busy     (core_busy),
        .core_time     (core_time),
        .q_enq         (q_enq),
        .q_enq_data    (q_enq_data),
        .q_deq         (q_deq),
        .q_head        (q_head),
        .q_empty       (q_empty),
        .q_full        (q_full),
        .gvt           (gvt),
        .done          (done),
        .running       (running),
        .err           (err),
        .n_dispatched  (n_dispatched)
    );

    typedef struct {
        logic [NC-1:0] ready;
        logic [NC-1:0] nvld;
        logic          empty;
        logic          full;
        int            null_core;
        logic [NC-1:0] e_ack;
        logic [NC-1:0] e_evt;
        logic          e_enq;
        logic          e_deq;
        int            e_src;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer message of core i: LP=i, time=1000+i, cancel=0.
    function automatic logic [MW-1:0] msg_of(input int i);
        logic [MW-1:0] m;
        m = '0;
        m[TW-1:0]    = TW'(1000 + i);
        m[TW +: LW]  = LW'(i);
        return m;
    endfunction

    function automatic logic [MW-1:0] init_msg(input int i);
        logic [MW-1:0] m;
        m = '0;
        m[TW +: LW] = LW'(i);
        return m;
    endfunction

    task automatic load_offers(input int null_core);
        for (int i = 0; i < NC; i++) begin
            core_new_data[i*MW +: MW] = (i == null_core) ? 32'h0020_0000 : msg_of(i);
        end
    endtask

    task automatic set_head(input int t);
        q_head = '0;
        q_head[TW-1:0] = TW'(t);
    endtask

    initial begin
        // ready, nvld, empty, full, null_core, e_ack, e_evt, e_enq, e_deq, e_src
        vt[0]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, -1, 16'h0000, 16'h0000, 1'b0, 1'b0, -1};
        vt[1]  = '{16'h0020, 16'h0008, 1'b0, 1'b0, -1, 16'h0008, 16'h0000, 1'b1, 1'b0,  3};
        vt[2]  = '{16'h0020, 16'h0000, 1'b0, 1'b0, -1, 16'h0000, 16'h0020, 1'b0, 1'b1, -1};
        vt[3]  = '{16'h0000, 16'h0080, 1'b0, 1'b0,  7, 16'h0080, 16'h0000, 1'b0, 1'b0, -1};
        vt[4]  = '{16'h0000, 16'h0204, 1'b0, 1'b0, -1, 16'h0200, 16'h0000, 1'b1, 1'b0,  9};
        vt[5]  = '{16'h0000, 16'h0204, 1'b0, 1'b0, -1, 16'h0004, 16'h0000, 1'b1, 1'b0,  2};
        vt[6]  = '{16'h0000, 16'h0204, 1'b0, 1'b0, -1, 16'h0200, 16'h0000, 1'b1, 1'b0,  9};
        vt[7]  = '{16'h0002, 16'h0010, 1'b0, 1'b1, -1, 16'h0000, 16'h0002, 1'b0, 1'b1, -1};
        vt[8]  = '{16'h0002, 16'h0010, 1'b0, 1'b0, -1, 16'h0010, 16'h0000, 1'b1, 1'b0,  4};
        vt[9]  = '{16'h8001, 16'h0000, 1'b0, 1'b0, -1, 16'h0000, 16'h8000, 1'b0, 1'b1, -1};
        vt[10] = '{16'h8001, 16'h0000, 1'b0, 1'b0, -1, 16'h0000, 16'h0001, 1'b0, 1'b1, -1};
        vt[11] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, -1, 16'h0000, 16'h0000, 1'b0, 1'b0, -1};
        vt[12] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0, -1, 16'h0000, 16'h0002, 1'b0, 1'b1, -1};

        rst_n = 1'b0; start = 1'b0; sim_end_time = 16'hFFFF; window = 16'd0;
        core_ready = '0; core_new_vld = '0; core_busy = '0; core_time = '0;
        q_empty = 1'b1; q_full = 1'b0; set_head(0); load_offers(-1);

        // Reset values
        tick(); tick();
        chk("rst_gvt", 64'(gvt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ndisp", 64'(n_dispatched), 64'd0);
        chk("rst_enq", 64'(q_enq), 64'd0);
        rst_n = 1'b1;
        tick();

        // Seeding: 32 consecutive enqueues LP 0..31, time 0
        start = 1'b1;
        #1;
        chk("idle_running", 64'(running), 64'd0);
        tick();
        start = 1'b0;
        chk("init_running", 64'(running), 64'd1);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("init_enq%0d", i), 64'(q_enq), 64'd1);
            chk($sformatf("init_data%0d", i), 64'(q_enq_data), 64'(init_msg(i)));
            tick();
        end
        chk("run_enq_idle", 64'(q_enq), 64'd0);
        chk("run_running", 64'(running), 64'd1);

        // Fairness: all cores ready, 40 queued events
        core_ready = '1; q_empty = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            chk($sformatf("fair_evt%0d", k), 64'(core_evt_vld), 64'(16'd1 << (k % 16)));
            chk($sformatf("fair_deq%0d", k), 64'(q_deq), 64'd1);
            tick();
        end
        core_ready = '0; q_empty = 1'b1;
        chk("fair_ndisp", 64'(n_dispatched), 64'd40);

        // Table: conflict, null filtering, full queue, arbiter rotation
        for (int v = 0; v < 13; v++) begin
            core_ready = vt[v].ready; core_new_vld = vt[v].nvld;
            q_empty = vt[v].empty; q_full = vt[v].full;
            load_offers(vt[v].null_core);
            #1;
            chk($sformatf("vec%0d_ack", v), 64'(core_new_ack), 64'(vt[v].e_ack));
            chk($sformatf("vec%0d_enq", v), 64'(q_enq), 64'(vt[v].e_enq));
            chk($sformatf("vec%0d_deq", v), 64'(q_deq), 64'(vt[v].e_deq));
            chk($sformatf("vec%0d_evt", v), 64'(core_evt_vld), 64'(vt[v].e_evt));
            if (vt[v].e_enq) begin
                chk($sformatf("vec%0d_data", v), 64'(q_enq_data), 64'(msg_of(vt[v].e_src)));
            end
            tick();
        end
        core_ready = '0; core_new_vld = '0; q_empty = 1'b1; q_full = 1'b0; load_offers(-1);
        chk("vec_ndisp", 64'(n_dispatched), 64'd45);

        // Window throttling
        window = 16'd50; core_busy = 16'h0001; core_time[0 +: TW] = 16'd100;
        set_head(150); q_empty = 1'b0; core_ready = 16'h0008;
        #1;
        chk("win_deq_g0", 64'(q_deq), 64'd0);
        tick();
        chk("win_gvt100", 64'(gvt), 64'd100);
        chk("win_deq_g100", 64'(q_deq), 64'd0);
        core_time[0 +: TW] = 16'd101;
        tick();
        chk("win_gvt101", 64'(gvt), 64'd101);
        chk("win_deq_g101", 64'(q_deq), 64'd1);
        chk("win_evt", 64'(core_evt_vld), 64'h0008);
        tick();
        core_ready = '0;
        chk("win_ndisp", 64'(n_dispatched), 64'd46);
        chk("win_err", 64'(err), 64'd0);

        // Termination and drain
        sim_end_time = 16'd200; window = 16'd0;
        core_busy = 16'h0003; core_time[0 +: TW] = 16'd201; core_time[TW +: TW] = 16'd250;
        set_head(300);
        tick();
        core_ready = 16'h0008;
        #1;
        chk("end_gvt201", 64'(gvt), 64'd201);
        chk("end_deq_gate", 64'(q_deq), 64'd0);
        tick();
        chk("drain_running", 64'(running), 64'd1);
        chk("drain_deq", 64'(q_deq), 64'd0);
        core_busy = '0; core_new_vld = 16'h0003;
        #1;
        chk("drain_ack0", 64'(core_new_ack), 64'h0001);
        chk("drain_enq0", 64'(q_enq), 64'd1);
        chk("drain_data0", 64'(q_enq_data), 64'(msg_of(0)));
        chk("drain_deq0", 64'(q_deq), 64'd0);
        tick();
        core_new_vld = 16'h0002;
        #1;
        chk("drain_ack1", 64'(core_new_ack), 64'h0002);
        chk("drain_data1", 64'(q_enq_data), 64'(msg_of(1)));
        tick();
        core_new_vld = '0;
        #1;
        chk("drain_hold_done", 64'(done), 64'd0);
        chk("drain_hold_run", 64'(running), 64'd1);
        tick();
        chk("fin_done", 64'(done), 64'd1);
        chk("fin_running", 64'(running), 64'd0);
        chk("fin_err", 64'(err), 64'd0);
        tick();
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_ndisp", 64'(n_dispatched), 64'd46);
        chk("idle_deq", 64'(q_deq), 64'd0);

        // Second run: full queue during INIT stalls and flags err
        core_ready = '0; q_empty = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; q_full = 1'b1;
        #1;
        chk("r2_clr_gvt", 64'(gvt), 64'd0);
        chk("r2_clr_ndisp", 64'(n_dispatched), 64'd0);
        chk("r2_full_enq", 64'(q_enq), 64'd1);
        tick();
        q_full = 1'b0;
        chk("r2_err", 64'(err), 64'd1);
        chk("r2_hold_lp", 64'(q_enq_data), 64'(init_msg(0)));
        for (int i = 0; i < NL; i++) begin
            tick();
        end
        chk("r2_run_enq", 64'(q_enq), 64'd0);
        core_busy = 16'h0004; core_time[2*TW +: TW] = 16'd500;
        tick();
        chk("r2_gvt500", 64'(gvt), 64'd500);
        tick();
        core_new_vld = 16'h0010;
        #1;
        chk("r2_drain_ack", 64'(core_new_ack), 64'h0010);

        // Async reset mid-DRAIN
        #1 rst_n = 1'b0;
        #1;
        chk("ar_ack", 64'(core_new_ack), 64'd0);
        chk("ar_enq", 64'(q_enq), 64'd0);
        chk("ar_running", 64'(running), 64'd0);
        chk("ar_gvt", 64'(gvt), 64'd0);
        chk("ar_err", 64'(err), 64'd0);
        core_new_vld = '0; core_busy = '0;
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r3_running", 64'(running), 64'd1);
        chk("r3_err", 64'(err), 64'd0);
        chk("r3_enq", 64'(q_enq), 64'd1);
        chk("r3_data", 64'(q_enq_data), 64'(init_msg(0)));
        tick();
        chk("r3_data1", 64'(q_enq_data), 64'(init_msg(1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
